rc_servo_frame_scheduler: RTL and testbench
===========================================

Name: rc_servo_frame_scheduler

Overview:
Frame-level controller for the XY servo output stage. It owns the 20 ms servo frame and shares one microsecond pulse timer between the X and Y channels: X pulse first, then Y, never overlapping. It accepts target positions through a valid/ready handshake and slews each channel's committed position toward its target by at most STEP counts per frame. It sits between the command source and the XY servo pads.

Parameters:
PRESCALE, 50, clk_i cycles per 1 us tick
FRAME_US, 20000, frame period in us
MIN_US, 1000, pulse width in us at position 0
SCALE_US, 4, us added per position count (pos 255 gives MIN_US+1020)
STEP, 8, maximum position change per frame per channel
CENTER, 128, reset position and reset target for both channels

Ports:
clk_i  in  1  clock
reset_i  in  1  synchronous, active-high reset
enable_i  in  1  run frames; sampled only at frame boundaries
tgt_x_i  in  8  X target position
tgt_y_i  in  8  Y target position
tgt_valid_i  in  1  target pair valid
tgt_ready_o  out  1  target pair accepted when valid&ready
pwm_x_o  out  1  X servo pulse
pwm_y_o  out  1  Y servo pulse
frame_o  out  1  1-cycle strobe at frame start (UPDATE)
busy_o  out  1  committed position != target on either channel
pos_x_o  out  8  committed X position
pos_y_o  out  8  committed Y position

Behaviour:
- Reset (synchronous on clk_i while reset_i=1): state IDLE; prescaler, us counter and frame counter = 0; pos_x/pos_y/tgt_x/tgt_y = CENTER; pwm_x_o=pwm_y_o=frame_o=busy_o=0; tgt_ready_o=0 while reset_i=1, 1 from the first cycle after.
- Reset mid-frame: both pwm outputs low on the next cycle (runt pulse allowed only in this case).
- us tick: prescaler counts 0..PRESCALE-1; tick on the terminal count; prescaler cleared in UPDATE.
- States:
  - IDLE: outputs low. enable_i=1 -> UPDATE.
  - UPDATE (1 cycle): frame_o=1, tgt_ready_o=0. Per channel: if pos<tgt, pos += min(STEP, tgt-pos); if pos>tgt, pos -= min(STEP, pos-tgt). Latch width = MIN_US + pos_new*SCALE_US (16-bit, no overflow). -> PULSE_X.
  - PULSE_X: pwm_x_o=1 for exactly width_x*PRESCALE cycles. -> PULSE_Y.
  - PULSE_Y: pwm_y_o=1 for exactly width_y*PRESCALE cycles. pwm_y_o rises in the same cycle pwm_x_o falls. -> WAIT.
  - WAIT: outputs low until the frame totals FRAME_US*PRESCALE cycles, counted from the UPDATE cycle. Then enable_i=1 -> UPDATE; enable_i=0 -> IDLE.
- enable_i is ignored inside a frame: a frame always completes both full pulses. There are no truncated pulses except on reset.
- frame_o period while enabled is exactly FRAME_US*PRESCALE cycles.
- Handshake:
  - tgt_ready_o=1 in every state except UPDATE and reset.
  - On valid&ready, tgt_x/tgt_y are latched; they take effect at the next UPDATE.
  - A newer accepted target overwrites an older unapplied one.
  - valid held across UPDATE is accepted on the following cycle.
- busy_o = (pos_x!=tgt_x)|(pos_y!=tgt_y), registered. It updates the cycle after the change.
- pwm_x_o and pwm_y_o are never high in the same cycle.
- Legal configuration: 2*(MIN_US+255*SCALE_US) < FRAME_US, checked at elaboration.

Test Plan:
For all tests: PRESCALE=2, FRAME_US=1200, MIN_US=100, SCALE_US=1, STEP=8, CENTER=128; reset, then enable_i=1.
1. Idle targets -> frame_o every 2400 cycles. pwm_x high 456 cycles starting the cycle after frame_o, then pwm_y high 456 cycles, then 1487 low cycles. No overlap.
2. Accept X target 200 -> pos_x 136,144,...,200 across 9 consecutive UPDATEs. busy_o=1 until after the 9th UPDATE. Frame-9 pwm_x width = 600 cycles. pos_y stays 128.
3. Accept X target 3 -> pos_x descends by 8 to 8 over 15 frames, then reaches 3 on frame 16 (clamped step of 5). Final pwm_x width = 206 cycles.
4. tgt_valid_i=1 asserted in the UPDATE cycle with (50,60) -> tgt_ready_o=0 that cycle; accepted the next cycle. Values are applied at the following frame, not the current one.
5. Drop enable_i in the middle of PULSE_X -> X and Y pulses complete at full width, WAIT completes, then IDLE: no further frame_o and outputs stay low. Re-enabling starts UPDATE within 1 cycle.
6. Assert reset_i in the middle of PULSE_Y -> pwm_y_o=0 the next cycle, pos_x_o=pos_y_o=128, tgt_ready_o=0 during reset. Frame restarts from UPDATE after release with enable_i=1.

Source files
------------

// File: rtl/rc_servo_frame_scheduler.sv
// XY servo frame controller: one frame timer, one shared microsecond pulse timer
// (X pulse then Y pulse), and per-frame slewing of committed positions toward targets.
`timescale 1ns/1ps
module rc_servo_frame_scheduler #(
  parameter int PRESCALE = 50,
  parameter int FRAME_US = 20000,
  parameter int MIN_US   = 1000,
  parameter int SCALE_US = 4,
  parameter int STEP     = 8,
  parameter int CENTER   = 128
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       enable_i,
  input  logic [7:0] tgt_x_i,
  input  logic [7:0] tgt_y_i,
  input  logic       tgt_valid_i,
  output logic       tgt_ready_o,
  output logic       pwm_x_o,
  output logic       pwm_y_o,
  output logic       frame_o,
  output logic       busy_o,
  output logic [7:0] pos_x_o,
  output logic [7:0] pos_y_o
);

  localparam int FRAME_CYC = FRAME_US * PRESCALE;
  localparam int FW        = $clog2(FRAME_CYC);
  localparam int PW        = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [FW-1:0] FRAME_LAST = FW'(FRAME_CYC - 1);
  localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);
  localparam logic [7:0]    CENTER_P   = 8'(CENTER);
  localparam logic [7:0]    STEP_P     = 8'(STEP);
  localparam logic [15:0]   MIN_P      = 16'(MIN_US);
  localparam logic [15:0]   SCALE_P    = 16'(SCALE_US);

  if (2 * (MIN_US + 255 * SCALE_US) >= FRAME_US) begin : g_bad_config
    $error("rc_servo_frame_scheduler: two maximum-width pulses do not fit in one frame");
  end

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_UPDATE  = 3'd1,
    ST_PULSE_X = 3'd2,
    ST_PULSE_Y = 3'd3,
    ST_WAIT    = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [15:0]   us_q, us_d;
  logic [FW-1:0] fcnt_q, fcnt_d;
  logic [7:0]    pos_x_q, pos_x_d, pos_y_q, pos_y_d;
  logic [7:0]    tgt_x_q, tgt_x_d, tgt_y_q, tgt_y_d;
  logic [15:0]   width_x_q, width_x_d, width_y_q, width_y_d;
  logic          pwm_x_q, pwm_y_q, frame_q, busy_q, ready_q;
  logic          tick_s;

  function automatic logic [7:0] slew(input logic [7:0] pos, input logic [7:0] tgt);
    logic [7:0] gap;
    logic [7:0] mv;
    gap = (pos < tgt) ? (tgt - pos) : (pos - tgt);
    mv  = (gap > STEP_P) ? STEP_P : gap;
    return (pos < tgt) ? (pos + mv) : (pos - mv);
  endfunction

  function automatic logic [15:0] pulse_us(input logic [7:0] pos);
    return MIN_P + 16'(pos) * SCALE_P;
  endfunction

  assign tick_s = (presc_q == PRESC_LAST);

  // Next state: frame sequencing, shared pulse timer, target capture and slewing.
  always_comb begin
    state_d   = state_q;
    presc_d   = tick_s ? {PW{1'b0}} : presc_q + PW'(1'b1);
    us_d      = us_q;
    fcnt_d    = fcnt_q + FW'(1'b1);
    pos_x_d   = pos_x_q;
    pos_y_d   = pos_y_q;
    width_x_d = width_x_q;
    width_y_d = width_y_q;
    if (tgt_valid_i && ready_q) begin
      tgt_x_d = tgt_x_i;
      tgt_y_d = tgt_y_i;
    end else begin
      tgt_x_d = tgt_x_q;
      tgt_y_d = tgt_y_q;
    end
    case (state_q)
      ST_IDLE: begin
        presc_d = {PW{1'b0}};
        us_d    = 16'd0;
        fcnt_d  = {FW{1'b0}};
        state_d = enable_i ? ST_UPDATE : ST_IDLE;
      end
      ST_UPDATE: begin
        // The UPDATE cycle is cycle 0 of the frame, so the count resumes at 1.
        presc_d   = {PW{1'b0}};
        us_d      = 16'd0;
        fcnt_d    = FW'(1'b1);
        pos_x_d   = slew(pos_x_q, tgt_x_q);
        pos_y_d   = slew(pos_y_q, tgt_y_q);
        width_x_d = pulse_us(pos_x_d);
        width_y_d = pulse_us(pos_y_d);
        state_d   = ST_PULSE_X;
      end
      ST_PULSE_X: begin
        if (tick_s && (us_q == width_x_q - 16'd1)) begin
          us_d    = 16'd0;
          state_d = ST_PULSE_Y;
        end else if (tick_s) begin
          us_d = us_q + 16'd1;
        end else begin
          us_d = us_q;
        end
      end
      ST_PULSE_Y: begin
        if (tick_s && (us_q == width_y_q - 16'd1)) begin
          us_d    = 16'd0;
          state_d = ST_WAIT;
        end else if (tick_s) begin
          us_d = us_q + 16'd1;
        end else begin
          us_d = us_q;
        end
      end
      ST_WAIT: begin
        if (fcnt_q == FRAME_LAST) begin
          state_d = enable_i ? ST_UPDATE : ST_IDLE;
        end else begin
          state_d = ST_WAIT;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers; outputs decode the next state so they line up with it.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q   <= ST_IDLE;
      presc_q   <= {PW{1'b0}};
      us_q      <= 16'd0;
      fcnt_q    <= {FW{1'b0}};
      pos_x_q   <= CENTER_P;
      pos_y_q   <= CENTER_P;
      tgt_x_q   <= CENTER_P;
      tgt_y_q   <= CENTER_P;
      width_x_q <= 16'd0;
      width_y_q <= 16'd0;
      pwm_x_q   <= 1'b0;
      pwm_y_q   <= 1'b0;
      frame_q   <= 1'b0;
      busy_q    <= 1'b0;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      presc_q   <= presc_d;
      us_q      <= us_d;
      fcnt_q    <= fcnt_d;
      pos_x_q   <= pos_x_d;
      pos_y_q   <= pos_y_d;
      tgt_x_q   <= tgt_x_d;
      tgt_y_q   <= tgt_y_d;
      width_x_q <= width_x_d;
      width_y_q <= width_y_d;
      pwm_x_q   <= (state_d == ST_PULSE_X);
      pwm_y_q   <= (state_d == ST_PULSE_Y);
      frame_q   <= (state_d == ST_UPDATE);
      busy_q    <= (pos_x_q != tgt_x_q) || (pos_y_q != tgt_y_q);
      ready_q   <= (state_d != ST_UPDATE);
    end
  end

  assign tgt_ready_o = ready_q;
  assign pwm_x_o     = pwm_x_q;
  assign pwm_y_o     = pwm_y_q;
  assign frame_o     = frame_q;
  assign busy_o      = busy_q;
  assign pos_x_o     = pos_x_q;
  assign pos_y_o     = pos_y_q;

endmodule

// File: tb/tb_rc_servo_frame_scheduler.sv
// Bench for rc_servo_frame_scheduler: per-frame vector table, directed corner
// sequences, and a frame-offset reference model checked on every cycle.
`timescale 1ns/1ps
module tb_rc_servo_frame_scheduler;

  localparam int P    = 2;
  localparam int FUS  = 1200;
  localparam int MINU = 100;
  localparam int SC   = 1;
  localparam int STP  = 8;
  localparam int CTR  = 128;
  localparam int FCYC = FUS * P;

  logic       clk = 1'b0;
  logic       reset_i = 1'b1;
  logic       enable_i = 1'b0;
  logic       tgt_valid_i = 1'b0;
  logic [7:0] tgt_x_i = 8'd0;
  logic [7:0] tgt_y_i = 8'd0;
  logic       tgt_ready_o, pwm_x_o, pwm_y_o, frame_o, busy_o;
  logic [7:0] pos_x_o, pos_y_o;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int nfr = 0;
  int last_fr_cyc = 0;
  int last_c = 0;
  int hx = 0;
  int hy = 0;

  typedef struct {
    bit load;
    int tx;
    int ty;
    int px;
    int py;
    bit busy;
    int wx;
  } rec_t;
  rec_t recs[25];

  rc_servo_frame_scheduler #(
    .PRESCALE(P), .FRAME_US(FUS), .MIN_US(MINU), .SCALE_US(SC), .STEP(STP), .CENTER(CTR)
  ) dut (
    .clk_i(clk), .reset_i(reset_i), .enable_i(enable_i),
    .tgt_x_i(tgt_x_i), .tgt_y_i(tgt_y_i), .tgt_valid_i(tgt_valid_i),
    .tgt_ready_o(tgt_ready_o), .pwm_x_o(pwm_x_o), .pwm_y_o(pwm_y_o),
    .frame_o(frame_o), .busy_o(busy_o), .pos_x_o(pos_x_o), .pos_y_o(pos_y_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d, want %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Frame strobe counter and per-frame pulse-width measurement.
  initial forever begin
    @(negedge clk);
    if (frame_o === 1'b1) begin
      nfr++;
      last_fr_cyc = cyc;
      hx = 0;
      hy = 0;
    end else begin
      if (pwm_x_o === 1'b1) hx++;
      if (pwm_y_o === 1'b1) hy++;
    end
  end

  // Reference model: frame offset from the UPDATE cycle decides every output.
  initial begin
    bit s_rst, s_en, s_v;
    int s_tx, s_ty;
    bit m_in, m_busy, m_ready, e_frame, e_px, e_py;
    int m_off, m_px, m_py, m_tx, m_ty, m_wx, m_wy;
    logic [20:0] exp_v, act_v;
    m_in = 0; m_off = 0; m_busy = 0; m_ready = 0;
    m_px = CTR; m_py = CTR; m_tx = CTR; m_ty = CTR; m_wx = 0; m_wy = 0;
    forever begin
      @(posedge clk);
      s_rst = reset_i; s_en = enable_i; s_v = tgt_valid_i;
      s_tx = int'(tgt_x_i); s_ty = int'(tgt_y_i);
      @(negedge clk);
      if (s_rst) begin
        m_in = 0; m_busy = 0;
        m_px = CTR; m_py = CTR; m_tx = CTR; m_ty = CTR;
      end else begin
        m_busy = (m_px != m_tx) || (m_py != m_ty);
        if (s_v && m_ready) begin
          m_tx = s_tx;
          m_ty = s_ty;
        end
        if (m_in && m_off == 0) begin
          if (m_tx > m_px) m_px = m_px + ((m_tx - m_px) < STP ? (m_tx - m_px) : STP);
          else if (m_tx < m_px) m_px = m_px - ((m_px - m_tx) < STP ? (m_px - m_tx) : STP);
          if (m_ty > m_py) m_py = m_py + ((m_ty - m_py) < STP ? (m_ty - m_py) : STP);
          else if (m_ty < m_py) m_py = m_py - ((m_py - m_ty) < STP ? (m_py - m_ty) : STP);
          m_wx = (MINU + m_px * SC) * P;
          m_wy = (MINU + m_py * SC) * P;
        end
        if (m_in) begin
          if (m_off == FCYC - 1) begin
            if (s_en) m_off = 0;
            else m_in = 0;
          end else begin
            m_off++;
          end
        end else if (s_en) begin
          m_in = 1;
          m_off = 0;
        end
      end
      e_frame = m_in && (m_off == 0);
      e_px    = m_in && (m_off >= 1) && (m_off <= m_wx);
      e_py    = m_in && (m_off > m_wx) && (m_off <= m_wx + m_wy);
      m_ready = !s_rst && !e_frame;
      exp_v = {e_px, e_py, e_frame, m_busy, m_ready, 8'(m_px), 8'(m_py)};
      act_v = {pwm_x_o, pwm_y_o, frame_o, busy_o, tgt_ready_o, pos_x_o, pos_y_o};
      total++;
      if (act_v !== exp_v) begin
        bad++;
        $display("FAIL model cycle %0d: got %h, want %h (pwmx,pwmy,frame,busy,ready,posx,posy)",
                 cyc, act_v, exp_v);
      end
    end
  end

  task automatic to_cycle(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_frame(output int c);
    int n0;
    int k;
    n0 = nfr;
    k = 0;
    while (nfr == n0 && k < FCYC + 50) begin
      @(posedge clk);
      #1;
      k++;
    end
    chk("frame_seen", nfr - n0, 1);
    c = last_fr_cyc;
    last_c = c;
  endtask

  task automatic send(input int tx, input int ty);
    tgt_x_i = 8'(tx);
    tgt_y_i = 8'(ty);
    tgt_valid_i = 1'b1;
    chk("ready_outside_update", int'(tgt_ready_o), 1);
    @(posedge clk);
    #1;
    tgt_valid_i = 1'b0;
  endtask

  task automatic run_recs(input int lo, input int hi);
    int c;
    int prev;
    for (int i = lo; i < hi; i++) begin
      if (recs[i].load) send(recs[i].tx, recs[i].ty);
      prev = last_c;
      wait_frame(c);
      chk("frame_period", c - prev, FCYC);
      to_cycle(c + 1500);
      chk("pos_x", int'(pos_x_o), recs[i].px);
      chk("pos_y", int'(pos_y_o), recs[i].py);
      chk("busy", int'(busy_o), int'(recs[i].busy));
      chk("width_x", hx, recs[i].wx);
    end
  endtask

  initial begin
    int c, u, n_at, px;
    for (int i = 0; i < 9; i++) begin
      px = CTR + STP * (i + 1);
      recs[i] = '{load: (i == 0), tx: 200, ty: CTR, px: px, py: CTR,
                  busy: (i < 8), wx: (MINU + px * SC) * P};
    end
    for (int j = 0; j < 16; j++) begin
      px = CTR - STP * (j + 1);
      if (px < 3) px = 3;
      recs[9 + j] = '{load: (j == 0), tx: 3, ty: CTR, px: px, py: CTR,
                      busy: (j < 15), wx: (MINU + px * SC) * P};
    end

    // Reset state, then idle-target frames.
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    chk("rst_ready", int'(tgt_ready_o), 0);
    chk("rst_pos_x", int'(pos_x_o), CTR);
    chk("rst_pwm", int'({pwm_x_o, pwm_y_o, frame_o, busy_o}), 0);
    reset_i = 1'b0;
    enable_i = 1'b1;
    wait_frame(c);
    to_cycle(c + 1500);
    chk("idle_width_x", hx, 456);
    chk("idle_width_y", hy, 456);

    // X slews up to 200 in steps of 8.
    run_recs(0, 9);

    // Reset in the middle of the Y pulse.
    wait_frame(c);
    to_cycle(c + 800);
    chk("mid_y_pwm_y", int'(pwm_y_o), 1);
    reset_i = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_kills_y", int'(pwm_y_o), 0);
    chk("rst_pos_x_mid", int'(pos_x_o), CTR);
    chk("rst_pos_y_mid", int'(pos_y_o), CTR);
    repeat (2) begin
      chk("rst_ready_mid", int'(tgt_ready_o), 0);
      @(posedge clk);
      #1;
    end
    reset_i = 1'b0;
    @(posedge clk);
    #1;
    chk("restart_update", int'(frame_o), 1);
    wait_frame(c);
    to_cycle(c + 1500);

    // X slews down to 3 with a final clamped step of 5.
    run_recs(9, 25);

    // Valid held across UPDATE is accepted next cycle and applied a frame later.
    u = last_c + FCYC;
    to_cycle(u);
    chk("upd_frame", int'(frame_o), 1);
    chk("upd_ready", int'(tgt_ready_o), 0);
    tgt_x_i = 8'd50;
    tgt_y_i = 8'd60;
    tgt_valid_i = 1'b1;
    @(posedge clk);
    #1;
    chk("post_upd_ready", int'(tgt_ready_o), 1);
    @(posedge clk);
    #1;
    tgt_valid_i = 1'b0;
    to_cycle(u + 1500);
    chk("late_pos_x", int'(pos_x_o), 3);
    chk("late_pos_y", int'(pos_y_o), CTR);
    chk("late_busy", int'(busy_o), 1);
    last_c = u;
    wait_frame(c);
    chk("late_period", c - u, FCYC);
    to_cycle(c + 1500);
    chk("applied_pos_x", int'(pos_x_o), 11);
    chk("applied_pos_y", int'(pos_y_o), 120);

    // Drop enable mid X pulse: frame completes, then idle; re-enable restarts at once.
    wait_frame(c);
    n_at = nfr;
    to_cycle(c + 100);
    enable_i = 1'b0;
    to_cycle(c + 1500);
    chk("dis_width_x", hx, (MINU + 19 * SC) * P);
    chk("dis_width_y", hy, (MINU + 112 * SC) * P);
    to_cycle(c + 3000);
    chk("dis_no_frame", nfr - n_at, 0);
    chk("dis_pwm_low", int'({pwm_x_o, pwm_y_o}), 0);
    enable_i = 1'b1;
    @(posedge clk);
    #1;
    chk("reenable_update", int'(frame_o), 1);

    // Random target traffic over two frames.
    for (int i = 0; i < 2 * FCYC; i++) begin
      tgt_valid_i = ($urandom_range(0, 7) == 0);
      tgt_x_i = 8'($urandom_range(0, 255));
      tgt_y_i = 8'($urandom_range(0, 255));
      @(posedge clk);
      #1;
    end
    tgt_valid_i = 1'b0;
    repeat (4) begin
      @(posedge clk);
      #1;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
